// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared types and constants for the 8259-style interrupt acknowledge sequencer.
package interrupt_ack_sequencer_pkg;

    localparam int         IR_WIDTH       = 8;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK1,
        WAIT_GAP,
        WAIT_ACK2,
        WAIT_END
    } ack_state_t;

    // Index of the set bit in a one-hot level vector (0 when empty).
    function automatic logic [2:0] onehot_to_level(input logic [IR_WIDTH-1:0] onehot);
        logic [2:0] level;
        level = '0;
        for (int i = 0; i < IR_WIDTH; i++) begin
            if (onehot[i]) level = 3'(i);
        end
        return level;
    endfunction

endpackage

// File: rtl/priority_resolver_fixed.sv
// Fixed-priority resolver: IR0 highest. Requests at or below the highest
// in-service level are masked, and the lowest remaining index is granted.
module priority_resolver_fixed
    import interrupt_ack_sequencer_pkg::*;
(
    input  logic [IR_WIDTH-1:0] request,
    input  logic [IR_WIDTH-1:0] in_service,
    output logic [IR_WIDTH-1:0] eligible,
    output logic [IR_WIDTH-1:0] grant
);

    logic [IR_WIDTH-1:0] allowed;
    logic                blocked;
    logic                found;

    // A level is allowed only if no level of equal or higher priority is in service.
    always_comb begin
        blocked = 1'b0;
        allowed = '0;
        for (int i = 0; i < IR_WIDTH; i++) begin
            blocked    = blocked | in_service[i];
            allowed[i] = ~blocked;
        end
    end

    assign eligible = request & allowed;

    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < IR_WIDTH; i++) begin
            if (eligible[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer: raises INT for eligible requests, walks the
// two-pulse INTA handshake, maintains the ISR and drives the vector byte.
module interrupt_ack_sequencer
    import interrupt_ack_sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [IR_WIDTH-1:0] interrupt_request_register,
    input  logic [IR_WIDTH-1:0] interrupt_mask,
    input  logic [4:0]          vector_base,
    input  logic                auto_eoi,
    input  logic                end_of_interrupt,
    input  logic                inta_n,
    output logic                interrupt_to_cpu,
    output logic                freeze,
    output logic [IR_WIDTH-1:0] clear_interrupt_request,
    output logic [IR_WIDTH-1:0] in_service_register,
    output logic [7:0]          data_out,
    output logic                data_out_enable
);

    ack_state_t          state;
    logic                inta_q;
    logic                inta_fall;
    logic                inta_rise;
    logic [IR_WIDTH-1:0] masked_request;
    logic [IR_WIDTH-1:0] eligible;
    logic [IR_WIDTH-1:0] request_grant;
    logic [IR_WIDTH-1:0] eoi_eligible;
    logic [IR_WIDTH-1:0] eoi_grant;
    logic [IR_WIDTH-1:0] eoi_clear;
    logic [IR_WIDTH-1:0] isr_set;
    logic [IR_WIDTH-1:0] isr_auto_clear;
    logic [2:0]          level;
    logic                spurious;

    assign inta_fall      = inta_q & ~inta_n;
    assign inta_rise      = ~inta_q & inta_n;
    assign masked_request = interrupt_request_register & ~interrupt_mask;

    priority_resolver_fixed u_request_resolver (
        .request    (masked_request),
        .in_service (in_service_register),
        .eligible   (eligible),
        .grant      (request_grant)
    );

    // With nothing masked, the grant is simply the highest-priority ISR bit.
    priority_resolver_fixed u_eoi_resolver (
        .request    (in_service_register),
        .in_service ('0),
        .eligible   (eoi_eligible),
        .grant      (eoi_grant)
    );

    assign eoi_clear = (end_of_interrupt && (|eoi_eligible)) ? eoi_grant : '0;

    // EOI/auto-EOI act on the registered ISR; a new set is OR-ed in afterwards.
    always_comb begin
        isr_set        = '0;
        isr_auto_clear = '0;
        if (state == WAIT_ACK1 && inta_fall) isr_set = request_grant;
        if (state == WAIT_END && inta_rise && auto_eoi && !spurious)
            isr_auto_clear = IR_WIDTH'(1) << level;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            inta_q                  <= 1'b1;
            interrupt_to_cpu        <= 1'b0;
            freeze                  <= 1'b0;
            clear_interrupt_request <= '0;
            in_service_register     <= '0;
            data_out                <= '0;
            data_out_enable         <= 1'b0;
            level                   <= SPURIOUS_LEVEL;
            spurious                <= 1'b0;
        end else begin
            inta_q                  <= inta_n;
            clear_interrupt_request <= '0;
            in_service_register     <= (in_service_register & ~eoi_clear & ~isr_auto_clear) | isr_set;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        state            <= WAIT_ACK1;
                        interrupt_to_cpu <= 1'b1;
                    end
                end
                WAIT_ACK1: begin
                    if (inta_fall) begin
                        state                   <= WAIT_GAP;
                        freeze                  <= 1'b1;
                        clear_interrupt_request <= request_grant;
                        if (|eligible) begin
                            level    <= onehot_to_level(request_grant);
                            spurious <= 1'b0;
                        end else begin
                            level    <= SPURIOUS_LEVEL;
                            spurious <= 1'b1;
                        end
                    end
                end
                WAIT_GAP: begin
                    if (inta_rise) state <= WAIT_ACK2;
                end
                WAIT_ACK2: begin
                    if (inta_fall) begin
                        state           <= WAIT_END;
                        data_out_enable <= 1'b1;
                        data_out        <= {vector_base, level};
                    end
                end
                WAIT_END: begin
                    if (inta_rise) begin
                        state            <= IDLE;
                        data_out_enable  <= 1'b0;
                        data_out         <= '0;
                        freeze           <= 1'b0;
                        interrupt_to_cpu <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer: cycle-by-cycle vector table plus
// hand-written multi-cycle sequences for spurious, auto-EOI, reset and EOI overlap.
module tb_interrupt_ack_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] interrupt_request_register;
    logic [7:0] interrupt_mask;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       end_of_interrupt;
    logic       inta_n;
    logic       interrupt_to_cpu;
    logic       freeze;
    logic [7:0] clear_interrupt_request;
    logic [7:0] in_service_register;
    logic [7:0] data_out;
    logic       data_out_enable;

    interrupt_ack_sequencer dut (
        .clock                      (clock),
        .reset                      (reset),
        .interrupt_request_register (interrupt_request_register),
        .interrupt_mask             (interrupt_mask),
        .vector_base                (vector_base),
        .auto_eoi                   (auto_eoi),
        .end_of_interrupt           (end_of_interrupt),
        .inta_n                     (inta_n),
        .interrupt_to_cpu           (interrupt_to_cpu),
        .freeze                     (freeze),
        .clear_interrupt_request    (clear_interrupt_request),
        .in_service_register        (in_service_register),
        .data_out                   (data_out),
        .data_out_enable            (data_out_enable)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [7:0] irr;
        logic [7:0] imr;
        logic [4:0] vb;
        logic       aeo;
        logic       eoi;
        logic       inta;
        logic       e_int;
        logic       e_frz;
        logic [7:0] e_clr;
        logic [7:0] e_isr;
        logic [7:0] e_dout;
        logic       e_doe;
    } vec_t;

    vec_t table_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   step_no = 0;

    task automatic check8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %02h, expected %02h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then compare.
    task automatic step(input vec_t t);
        reset                      = t.rst;
        interrupt_request_register = t.irr;
        interrupt_mask             = t.imr;
        vector_base                = t.vb;
        auto_eoi                   = t.aeo;
        end_of_interrupt           = t.eoi;
        inta_n                     = t.inta;
        @(posedge clock);
        #1;
        check8("interrupt_to_cpu", step_no, {7'b0, interrupt_to_cpu}, {7'b0, t.e_int});
        check8("freeze",           step_no, {7'b0, freeze},           {7'b0, t.e_frz});
        check8("clear_irr",        step_no, clear_interrupt_request,  t.e_clr);
        check8("isr",              step_no, in_service_register,      t.e_isr);
        check8("data_out",         step_no, data_out,                 t.e_dout);
        check8("data_out_enable",  step_no, {7'b0, data_out_enable},  {7'b0, t.e_doe});
        step_no++;
    endtask

    function automatic vec_t mk(input logic rst, input logic [7:0] irr, input logic [7:0] imr,
                                input logic [4:0] vb, input logic aeo, input logic eoi, input logic inta,
                                input logic e_int, input logic e_frz, input logic [7:0] e_clr,
                                input logic [7:0] e_isr, input logic [7:0] e_dout, input logic e_doe);
        vec_t t;
        t.rst = rst; t.irr = irr; t.imr = imr; t.vb = vb; t.aeo = aeo; t.eoi = eoi; t.inta = inta;
        t.e_int = e_int; t.e_frz = e_frz; t.e_clr = e_clr; t.e_isr = e_isr;
        t.e_dout = e_dout; t.e_doe = e_doe;
        return t;
    endfunction

    task automatic add(input logic rst, input logic [7:0] irr, input logic [7:0] imr,
                       input logic [4:0] vb, input logic aeo, input logic eoi, input logic inta,
                       input logic e_int, input logic e_frz, input logic [7:0] e_clr,
                       input logic [7:0] e_isr, input logic [7:0] e_dout, input logic e_doe);
        table_q.push_back(mk(rst, irr, imr, vb, aeo, eoi, inta, e_int, e_frz, e_clr, e_isr, e_dout, e_doe));
    endtask

    task automatic run(input logic rst, input logic [7:0] irr, input logic [7:0] imr,
                       input logic [4:0] vb, input logic aeo, input logic eoi, input logic inta,
                       input logic e_int, input logic e_frz, input logic [7:0] e_clr,
                       input logic [7:0] e_isr, input logic [7:0] e_dout, input logic e_doe);
        step(mk(rst, irr, imr, vb, aeo, eoi, inta, e_int, e_frz, e_clr, e_isr, e_dout, e_doe));
    endtask

    initial begin
        reset = 1'b1; interrupt_request_register = '0; interrupt_mask = '0;
        vector_base = 5'h08; auto_eoi = 1'b0; end_of_interrupt = 1'b0; inta_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        //   rst irr    imr    vb    aeo eoi inta | int frz clr    isr    dout   doe
        add(1, 8'h00, 8'h00, 5'h08, 0, 0, 1,   0, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h00, 8'h00, 5'h08, 0, 0, 0,   0, 0, 8'h00, 8'h00, 8'h00, 0); // INTA in IDLE ignored
        add(0, 8'h00, 8'h00, 5'h08, 0, 0, 1,   0, 0, 8'h00, 8'h00, 8'h00, 0);
        // IR2, base 0x08 -> vector 0x42
        add(0, 8'h04, 8'h00, 5'h08, 0, 0, 1,   1, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h04, 8'h00, 5'h08, 0, 0, 0,   1, 1, 8'h04, 8'h04, 8'h00, 0);
        add(0, 8'h00, 8'h00, 5'h08, 0, 0, 0,   1, 1, 8'h00, 8'h04, 8'h00, 0);
        add(0, 8'h00, 8'h00, 5'h08, 0, 0, 1,   1, 1, 8'h00, 8'h04, 8'h00, 0);
        add(0, 8'h00, 8'h00, 5'h08, 0, 0, 1,   1, 1, 8'h00, 8'h04, 8'h00, 0);
        add(0, 8'h00, 8'h00, 5'h08, 0, 0, 0,   1, 1, 8'h00, 8'h04, 8'h42, 1);
        add(0, 8'h00, 8'h00, 5'h08, 0, 0, 0,   1, 1, 8'h00, 8'h04, 8'h42, 1);
        add(0, 8'h00, 8'h00, 5'h08, 0, 0, 1,   0, 0, 8'h00, 8'h04, 8'h00, 0);
        add(0, 8'h00, 8'h00, 5'h08, 0, 1, 1,   0, 0, 8'h00, 8'h00, 8'h00, 0);
        // IRR=0x90 with IR4 masked -> IR7, vector 0x47
        add(0, 8'h90, 8'h10, 5'h08, 0, 0, 1,   1, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h90, 8'h10, 5'h08, 0, 0, 0,   1, 1, 8'h80, 8'h80, 8'h00, 0);
        add(0, 8'h10, 8'h10, 5'h08, 0, 0, 0,   1, 1, 8'h00, 8'h80, 8'h00, 0);
        add(0, 8'h10, 8'h10, 5'h08, 0, 0, 1,   1, 1, 8'h00, 8'h80, 8'h00, 0);
        add(0, 8'h10, 8'h10, 5'h08, 0, 0, 0,   1, 1, 8'h00, 8'h80, 8'h47, 1);
        add(0, 8'h10, 8'h10, 5'h08, 0, 0, 1,   0, 0, 8'h00, 8'h80, 8'h00, 0);
        add(0, 8'h10, 8'h10, 5'h08, 0, 1, 1,   0, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h00, 8'h10, 5'h08, 0, 0, 1,   0, 0, 8'h00, 8'h00, 8'h00, 0);
        // ISR=0x02 blocks IR3 until EOI
        add(0, 8'h02, 8'h00, 5'h08, 0, 0, 1,   1, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h02, 8'h00, 5'h08, 0, 0, 0,   1, 1, 8'h02, 8'h02, 8'h00, 0);
        add(0, 8'h00, 8'h00, 5'h08, 0, 0, 1,   1, 1, 8'h00, 8'h02, 8'h00, 0);
        add(0, 8'h00, 8'h00, 5'h08, 0, 0, 0,   1, 1, 8'h00, 8'h02, 8'h41, 1);
        add(0, 8'h00, 8'h00, 5'h08, 0, 0, 1,   0, 0, 8'h00, 8'h02, 8'h00, 0);
        add(0, 8'h08, 8'h00, 5'h08, 0, 0, 1,   0, 0, 8'h00, 8'h02, 8'h00, 0);
        add(0, 8'h08, 8'h00, 5'h08, 0, 0, 1,   0, 0, 8'h00, 8'h02, 8'h00, 0);
        add(0, 8'h08, 8'h00, 5'h08, 0, 1, 1,   0, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h08, 8'h00, 5'h08, 0, 0, 1,   1, 0, 8'h00, 8'h00, 8'h00, 0);

        for (int i = 0; i < table_q.size(); i++) step(table_q[i]);

        // Spurious: IR0 withdrawn before the first INTA -> IR7 vector, no clear, no ISR
        run(1, 8'h00, 8'h00, 5'h15, 0, 0, 1,   0, 0, 8'h00, 8'h00, 8'h00, 0);
        run(0, 8'h01, 8'h00, 5'h15, 0, 0, 1,   1, 0, 8'h00, 8'h00, 8'h00, 0);
        run(0, 8'h00, 8'h00, 5'h15, 0, 0, 1,   1, 0, 8'h00, 8'h00, 8'h00, 0);
        run(0, 8'h00, 8'h00, 5'h15, 0, 0, 0,   1, 1, 8'h00, 8'h00, 8'h00, 0);
        run(0, 8'h00, 8'h00, 5'h15, 0, 0, 1,   1, 1, 8'h00, 8'h00, 8'h00, 0);
        run(0, 8'h00, 8'h00, 5'h15, 0, 0, 0,   1, 1, 8'h00, 8'h00, 8'hAF, 1);
        run(0, 8'h00, 8'h00, 5'h15, 0, 0, 1,   0, 0, 8'h00, 8'h00, 8'h00, 0);

        // Auto-EOI on IR5: ISR set after first INTA, cleared when the second INTA rises
        run(0, 8'h20, 8'h00, 5'h1A, 1, 0, 1,   1, 0, 8'h00, 8'h00, 8'h00, 0);
        run(0, 8'h20, 8'h00, 5'h1A, 1, 0, 0,   1, 1, 8'h20, 8'h20, 8'h00, 0);
        run(0, 8'h00, 8'h00, 5'h1A, 1, 0, 1,   1, 1, 8'h00, 8'h20, 8'h00, 0);
        run(0, 8'h00, 8'h00, 5'h1A, 1, 0, 0,   1, 1, 8'h00, 8'h20, 8'hD5, 1);
        run(0, 8'h00, 8'h00, 5'h1A, 1, 0, 1,   0, 0, 8'h00, 8'h00, 8'h00, 0);

        // Reset while in WAIT_ACK2 aborts: no vector, ISR wiped, INTA low after reset ignored
        run(0, 8'h08, 8'h00, 5'h08, 0, 0, 1,   1, 0, 8'h00, 8'h00, 8'h00, 0);
        run(0, 8'h08, 8'h00, 5'h08, 0, 0, 0,   1, 1, 8'h08, 8'h08, 8'h00, 0);
        run(0, 8'h00, 8'h00, 5'h08, 0, 0, 1,   1, 1, 8'h00, 8'h08, 8'h00, 0);
        run(1, 8'h00, 8'h00, 5'h08, 0, 0, 0,   0, 0, 8'h00, 8'h00, 8'h00, 0);
        run(0, 8'h00, 8'h00, 5'h08, 0, 0, 0,   0, 0, 8'h00, 8'h00, 8'h00, 0);
        run(0, 8'h00, 8'h00, 5'h08, 0, 0, 1,   0, 0, 8'h00, 8'h00, 8'h00, 0);

        // EOI coinciding with an ISR set: IR1 is set, the older IR3 bit is retired
        run(0, 8'h08, 8'h00, 5'h08, 0, 0, 1,   1, 0, 8'h00, 8'h00, 8'h00, 0);
        run(0, 8'h08, 8'h00, 5'h08, 0, 0, 0,   1, 1, 8'h08, 8'h08, 8'h00, 0);
        run(0, 8'h00, 8'h00, 5'h08, 0, 0, 1,   1, 1, 8'h00, 8'h08, 8'h00, 0);
        run(0, 8'h00, 8'h00, 5'h08, 0, 0, 0,   1, 1, 8'h00, 8'h08, 8'h43, 1);
        run(0, 8'h00, 8'h00, 5'h08, 0, 0, 1,   0, 0, 8'h00, 8'h08, 8'h00, 0);
        run(0, 8'h02, 8'h00, 5'h08, 0, 0, 1,   1, 0, 8'h00, 8'h08, 8'h00, 0);
        run(0, 8'h02, 8'h00, 5'h08, 0, 1, 0,   1, 1, 8'h02, 8'h02, 8'h00, 0);
        run(1, 8'h00, 8'h00, 5'h08, 0, 0, 1,   0, 0, 8'h00, 8'h00, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clock` and `reset`.
REQ-002 Ports SHALL be as follows, each listed as name, direction, width, meaning:
- `clock` in 1: rising-edge system clock.
- `reset` in 1: synchronous, active-high reset.
- `interrupt_request_register` in 8: IRR contents, bit n = IRn pending.
- `interrupt_mask` in 8: IMR; bit set = level masked.
- `vector_base` in 5: ICW2 T7..T3.
- `auto_eoi` in 1: 1 = clear the ISR bit automatically at the end of the second INTA.
- `end_of_interrupt` in 1: one-cycle non-specific EOI strobe.
- `inta_n` in 1: CPU acknowledge, active low, already synchronous to `clock`.
- `interrupt_to_cpu` out 1: INT pin.
- `freeze` out 1: holds the IRR during the acknowledge sequence.
- `clear_interrupt_request` out 8: one-hot, one-cycle clear of the IRR bit.
- `in_service_register` out 8: ISR.
- `data_out` out 8: vector byte.
- `data_out_enable` out 1: drives the data bus.

Function
REQ-003 Priority SHALL be fixed: IR0 highest, IR7 lowest.
REQ-004 `eligible` SHALL equal IRR & ~IMR restricted to levels strictly higher than the highest set ISR bit.
REQ-005 The FSM SHALL have states IDLE, WAIT_ACK1, WAIT_GAP, WAIT_ACK2 and WAIT_END.
REQ-006 A falling INTA edge SHALL be defined as registered `inta_n`=1 with current `inta_n`=0; a rising edge is the reverse.
REQ-007 In IDLE, when `eligible` is nonzero, the FSM SHALL go to WAIT_ACK1 and assert `interrupt_to_cpu` from the next cycle.
REQ-008 In WAIT_ACK1, a falling INTA edge SHALL trigger all of the following in the same cycle:
- latch the highest-priority eligible level L;
- assert `freeze`;
- drive `clear_interrupt_request` = 1<<L for exactly that cycle;
- set ISR[L] on the next edge;
- go to WAIT_GAP.
REQ-009 If `eligible` is 0 at the first falling INTA edge (request withdrawn), the block SHALL select L=7, leave the ISR unchanged, and issue no clear (spurious IR7).
REQ-010 In WAIT_GAP, a rising INTA edge SHALL move the FSM to WAIT_ACK2.
REQ-011 In WAIT_ACK2, a falling INTA edge SHALL assert `data_out_enable` and drive `data_out` = {`vector_base`, L[2:0]} while `inta_n` stays low, then go to WAIT_END.
REQ-012 In WAIT_END, a rising INTA edge SHALL trigger all of the following and return the FSM to IDLE:
- deassert `data_out_enable`, `freeze` and `interrupt_to_cpu`;
- if `auto_eoi`=1 and the sequence was not spurious, clear ISR[L].
REQ-013 `end_of_interrupt` SHALL clear the highest-priority set ISR bit in any state.
REQ-014 If `end_of_interrupt` and an ISR set occur in the same cycle, the set SHALL be applied and the EOI SHALL act on the pre-existing bits only.
REQ-015 `data_out` SHALL be 0 whenever `data_out_enable`=0.
REQ-016 INTA edges received in IDLE SHALL be ignored.
REQ-017 `interrupt_to_cpu` SHALL stay asserted until the end of the sequence, even if the request or mask changes after WAIT_ACK1.

Reset
REQ-018 While `reset`=1, the block SHALL:
- hold the FSM in IDLE;
- force `interrupt_to_cpu`=0, `freeze`=0, `clear_interrupt_request`=0, `in_service_register`=0, `data_out`=0 and `data_out_enable`=0;
- set the registered `inta_n` to 1.
REQ-019 A reset mid-sequence SHALL abort the sequence immediately, with no vector driven and no ISR update.

Structure
REQ-020 The shared package SHALL contain:
- the FSM state typedef;
- the constants IR_WIDTH=8 and SPURIOUS_LEVEL=7.
REQ-021 One sub-module, `priority_resolver_fixed` (8-bit one-hot lowest-index-first select with ISR masking), SHALL be instantiated twice: once for request selection and once for EOI.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- IRR=0x04, IMR=0, two INTA pulses, `vector_base`=0x08 → INT high; one-cycle clear=0x04; ISR=0x04; `data_out`=0x42 during the second INTA; INT low after it.
- IRR=0x90, IMR=0x10 → L=7, vector {base,7}; the IR4 request is ignored.
- ISR=0x02, IRR=0x08 → INT stays 0; after EOI strobe → ISR=0, then INT rises.
- IRR pulses 0x01 then drops before the first INTA → spurious: vector {base,7}, ISR unchanged, clear=0.
- `auto_eoi`=1, IRR=0x20 → ISR=0x20 after the first INTA, back to 0 after the second INTA rises.
- Reset asserted during WAIT_ACK2 → all outputs 0 on the next cycle; no vector driven.
